// File: rtl/counter_mod_step.sv
// counter_mod_step
//   Loadable up/down counter with a programmable modulus (MAX+1) and a
//   per-cycle step size. Carry/borrow event pulses are registered
//   alongside the count. ZERO and FULL status flags are decoded directly
//   from the count register.
//
//   Build option: define COUNTER_SAT_EN for saturating behaviour.
//   In that mode, up-count clamps at MAX with CO=1, and down-count clamps
//   at 0 with BO=1. Without the macro the counter wraps modulo MAX+1.
//
// Parameters
//   WIDTH  : counter width in bits (2..32)
//   MAX    : top count value (1..2**WIDTH-1)
//   STEP_W : width of STEP (1..WIDTH)
//
// Ports
//   CLK   in   rising-edge clock
//   RST_N in   asynchronous active-low reset (clears Q, CO, BO)
//   EN    in   count/load enable; 0 holds
//   S     in   function: 00 hold, 01 load, 10 up, 11 down
//   D     in   load data (clamped to MAX)
//   STEP  in   step amount (clamped to MAX)
//   Q     out  registered count
//   CO    out  registered carry event pulse
//   BO    out  registered borrow event pulse
//   ZERO  out  Q == 0
//   FULL  out  Q == MAX
module counter_mod_step #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned MAX    = 2**WIDTH - 1,
    parameter int unsigned STEP_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic [1:0]        S,
    input  logic [WIDTH-1:0]  D,
    input  logic [STEP_W-1:0] STEP,
    output logic [WIDTH-1:0]  Q,
    output logic              CO,
    output logic              BO,
    output logic              ZERO,
    output logic              FULL
);

    // All arithmetic is one bit wider than the count so that Q+s and
    // Q+(MAX+1) never overflow before the modulus correction.
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0] MOD_X = MAX_X + 1'b1;

    logic [WIDTH:0]   q_x;
    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   s_x;
    logic [WIDTH:0]   d_x;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH-1:0] q_next;
    logic             co_next;
    logic             bo_next;

    always_comb begin
        q_x    = {1'b0, Q};
        step_x = (WIDTH+1)'(STEP);
        d_x    = {1'b0, D};
        s_x    = (step_x > MAX_X) ? MAX_X : step_x;
        sum_x  = q_x + s_x;

        q_next  = Q;
        co_next = 1'b0;
        bo_next = 1'b0;

        if (EN) begin
            unique case (S)
                2'b00: ;
                2'b01: q_next = (d_x > MAX_X) ? WIDTH'(MAX_X) : D;
                2'b10: begin
                    if (sum_x > MAX_X) begin
                        co_next = 1'b1;
`ifdef COUNTER_SAT_EN
                        q_next  = WIDTH'(MAX_X);
`else
                        q_next  = WIDTH'(sum_x - MOD_X);
`endif
                    end else begin
                        q_next = WIDTH'(sum_x);
                    end
                end
                2'b11: begin
                    if (s_x > q_x) begin
                        bo_next = 1'b1;
`ifdef COUNTER_SAT_EN
                        q_next  = '0;
`else
                        q_next  = WIDTH'(q_x + MOD_X - s_x);
`endif
                    end else begin
                        q_next = WIDTH'(q_x - s_x);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q  <= '0;
            CO <= 1'b0;
            BO <= 1'b0;
        end else begin
            Q  <= q_next;
            CO <= co_next;
            BO <= bo_next;
        end
    end

    assign ZERO = (Q == '0);
    assign FULL = (q_x == MAX_X);

endmodule

// File: tb/tb_counter_mod_step.sv
// Testbench for counter_mod_step (WIDTH=4, MAX=9, STEP_W=4).
// Directed scenarios followed by a randomized run, all checked against an
// integer reference model of the counter rules. Define COUNTER_SAT_EN for
// both the bench and the RTL to exercise saturating mode.
module tb_counter_mod_step;

    localparam int WIDTH  = 4;
    localparam int MAX    = 9;
    localparam int STEP_W = 4;

    logic              CLK;
    logic              RST_N;
    logic              EN;
    logic [1:0]        S;
    logic [WIDTH-1:0]  D;
    logic [STEP_W-1:0] STEP;
    logic [WIDTH-1:0]  Q;
    logic              CO;
    logic              BO;
    logic              ZERO;
    logic              FULL;

    int tests;
    int fails;

    // Reference model state
    int mq;
    int mco;
    int mbo;

    counter_mod_step #(
        .WIDTH (WIDTH),
        .MAX   (MAX),
        .STEP_W(STEP_W)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .EN   (EN),
        .S    (S),
        .D    (D),
        .STEP (STEP),
        .Q    (Q),
        .CO   (CO),
        .BO   (BO),
        .ZERO (ZERO),
        .FULL (FULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model of one active edge, written from the counter rules.
    task automatic model_edge(input int en, input int s, input int d, input int st);
        int eff;
        int t;
        eff = (st > MAX) ? MAX : st;
        mco = 0;
        mbo = 0;
        if (en != 0) begin
            case (s)
                1: mq = (d > MAX) ? MAX : d;
                2: begin
                    t = mq + eff;
                    if (t > MAX) begin
                        mco = 1;
`ifdef COUNTER_SAT_EN
                        mq = MAX;
`else
                        mq = t % (MAX + 1);
`endif
                    end else begin
                        mq = t;
                    end
                end
                3: begin
                    t = mq - eff;
                    if (t < 0) begin
                        mbo = 1;
`ifdef COUNTER_SAT_EN
                        mq = 0;
`else
                        mq = t + MAX + 1;
`endif
                    end else begin
                        mq = t;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".q"},    Q,    mq);
        chk({tag, ".co"},   CO,   mco);
        chk({tag, ".bo"},   BO,   mbo);
        chk({tag, ".zero"}, ZERO, (mq == 0) ? 1 : 0);
        chk({tag, ".full"}, FULL, (mq == MAX) ? 1 : 0);
    endtask

    // Drive inputs away from the edge, clock once, sample 1ns after.
    task automatic tick(input string tag, input int en, input int s, input int d, input int st);
        EN   = 1'(en);
        S    = 2'(s);
        D    = WIDTH'(d);
        STEP = STEP_W'(st);
        model_edge(en, s, d, st);
        @(posedge CLK);
        #1;
        check_model(tag);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        mq = 0; mco = 0; mbo = 0;
        RST_N = 1'b0;
        EN = 1'b0; S = 2'b00; D = '0; STEP = '0;

        // Reset state
        #2;
        chk("rst.q", Q, 0);
        chk("rst.zero", ZERO, 1);
        chk("rst.full", FULL, 0);
        chk("rst.co", CO, 0);
        chk("rst.bo", BO, 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        // 1. Asynchronous reset mid-cycle
        tick("ld5", 1, 1, 5, 0);
        chk("ld5.const", Q, 5);
        #3;
        RST_N = 1'b0;
        #1;
        mq = 0; mco = 0; mbo = 0;
        chk("async.q", Q, 0);
        chk("async.zero", ZERO, 1);
        chk("async.co", CO, 0);
        chk("async.bo", BO, 0);
        EN = 1'b1; S = 2'b10; STEP = 4'd3;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            chk("rsthold.q", Q, 0);
        end
        S = 2'b01; D = 4'd6;
        @(posedge CLK); #1;
        chk("rsthold.ld", Q, 0);
        RST_N = 1'b1;

        // 2. Load and clamp
        tick("ld7", 1, 1, 7, 0);
        chk("ld7.const", Q, 7);
        tick("ld12", 1, 1, 12, 0);
        chk("ld12.const", Q, 9);
        chk("ld12.full", FULL, 1);

`ifndef COUNTER_SAT_EN
        // 3. Up wrap
        tick("ld8", 1, 1, 8, 0);
        tick("up3", 1, 2, 0, 3);
        chk("up3.q", Q, 1);
        chk("up3.co", CO, 1);
        tick("up1", 1, 2, 0, 1);
        chk("up1.q", Q, 2);
        chk("up1.co", CO, 0);
        tick("up15", 1, 2, 0, 15);
        chk("up15.q", Q, 1);
        chk("up15.co", CO, 1);

        // 4. Down wrap
        tick("dn2", 1, 3, 0, 2);
        chk("dn2.q", Q, 9);
        chk("dn2.bo", BO, 1);
        chk("dn2.full", FULL, 1);
        tick("dn9", 1, 3, 0, 9);
        chk("dn9.q", Q, 0);
        chk("dn9.bo", BO, 0);
        chk("dn9.zero", ZERO, 1);
`else
        // 6. Saturating mode
        tick("ld8", 1, 1, 8, 0);
        tick("sup3a", 1, 2, 0, 3);
        chk("sup3a.q", Q, 9);
        chk("sup3a.co", CO, 1);
        tick("sup3b", 1, 2, 0, 3);
        chk("sup3b.q", Q, 9);
        chk("sup3b.co", CO, 1);
        tick("ld1", 1, 1, 1, 0);
        tick("sdn2", 1, 3, 0, 2);
        chk("sdn2.q", Q, 0);
        chk("sdn2.bo", BO, 1);
        tick("ld4", 1, 1, 4, 0);
        chk("ld4.q", Q, 4);
        chk("ld4.bo", BO, 0);
`endif

        // 5. Hold paths
        tick("ld3", 1, 1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            tick("en0", 0, 2, 0, 3);
            chk("en0.q", Q, 3);
        end
        for (int i = 0; i < 3; i++) begin
            tick("s00", 1, 0, 0, 3);
            chk("s00.q", Q, 3);
        end
        tick("upz", 1, 2, 0, 0);
        chk("upz.q", Q, 3);
        chk("upz.co", CO, 0);
        tick("dnz", 1, 3, 0, 0);
        chk("dnz.q", Q, 3);
        chk("dnz.bo", BO, 0);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            int en;
            en = ($urandom_range(0, 7) != 0) ? 1 : 0;
            tick("rnd", en, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
